// File: rtl/match_event_logger.sv
// Logs the stream index of every qualified 1011 match into a small FWFT FIFO,
// with a saturating match count, sticky overflow and an interrupt level.
module match_event_logger #(
  parameter int POS_W = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             bit_vld_i,
  input  logic             match_i,
  input  logic             pop_i,
  output logic             evt_vld_o,
  output logic [POS_W-1:0] evt_pos_o,
  output logic [CNT_W-1:0] evt_cnt_o,
  output logic             ovf_o,
  output logic             irq_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] HALF = OCC_W'(DEPTH / 2);

  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [OCC_W-1:0] occ;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic qual;
  logic empty;
  logic full;
  logic do_pop;
  logic do_push;
  logic drop;

  // A pop on a full FIFO frees the slot the same-cycle push needs.
  always_comb begin
    qual    = bit_vld_i & match_i;
    empty   = (occ == '0);
    full    = (occ == FULL);
    do_pop  = pop_i & ~empty;
    do_push = qual & (~full | do_pop);
    drop    = qual & full & ~do_pop;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pos  <= '0;
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_i) begin
      pos  <= '0;
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (bit_vld_i) pos <= pos + POS_W'(1);
      if (do_push) begin
        mem[wptr] <= pos;
        wptr      <= wptr + PTR_W'(1);
      end
      if (do_pop) rptr <= rptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      if (qual && cnt != '1) cnt <= cnt + CNT_W'(1);
      if (drop) ovf <= 1'b1;
    end
  end

  always_comb begin
    evt_vld_o = ~empty;
    evt_pos_o = empty ? '0 : mem[rptr];
    evt_cnt_o = cnt;
    ovf_o     = ovf;
    irq_o     = ovf | (occ >= HALF);
  end

endmodule
